// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles, branch squashes,
// data-memory waits with a sticky timeout, and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [31:0]      stall_count,
    output logic             mem_timeout_err
);

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        err_q, err_d;
    logic [31:0] stall_q, stall_d;
    logic        lu;
    logic        mem_stall;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign lu = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemWait;
                    wait_d  = 8'd1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StRun;
                    wait_d  = 8'd0;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StRun;
                wait_d  = 8'd0;
            end
        endcase

        stall_d = stall_q;
        if ((state_q == StRun || state_q == StMemWait) && !pc_en && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        pc_en = 1'b0;
                    end else if (branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EX.
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                StMemWait: begin
                    if (mem_ready) begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    assign stall_count     = stall_q;
    assign mem_timeout_err = err_q;

endmodule
